// File: rtl/vector_scale_seq.sv
// rtl/vector_scale_seq.sv - sequential float32 vector-by-scalar scaler using MOD_COUNT multiplier lanes
module vector_scale_seq #(
  parameter int VLEN      = 1,
  parameter int MOD_COUNT = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [31:0]          S,
  input  logic [32*VLEN-1:0]   V,
  output logic [32*VLEN-1:0]   result,
  output logic                 busy,
  output logic                 done
);

  // index must reach VLEN+MOD_COUNT-1 without wrapping
  localparam int IW = $clog2(VLEN + MOD_COUNT);
  localparam int W  = 32 * VLEN;
  localparam logic [IW-1:0] MC_W = IW'(MOD_COUNT);
  localparam logic [IW-1:0] VL_W = IW'(VLEN);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state, state_next;
  logic [31:0]     s_reg;
  logic [W-1:0]    v_reg;
  logic [W-1:0]    work;
  logic [W-1:0]    work_next;
  logic [IW-1:0]   idx;
  logic            accept;
  logic            last;
  logic [31:0]     lane_v   [MOD_COUNT];
  logic [31:0]     lane_out [MOD_COUNT];

  // lanes share the captured scalar; each multiplies one element of the current chunk
  genvar g;
  generate
    for (g = 0; g < MOD_COUNT; g++) begin : g_lane
      FloatingMultiplication u_mul (
        .a (s_reg),
        .b (lane_v[g]),
        .y (lane_out[g])
      );
    end
  endgenerate

  // route element idx+l to lane l; lanes past the vector end see zero
  always_comb begin
    for (int l = 0; l < MOD_COUNT; l++) begin
      lane_v[l] = '0;
      for (int e = 0; e < VLEN; e++) begin
        if (idx + IW'(l) == IW'(e)) lane_v[l] = v_reg[32*e +: 32];
      end
    end
  end

  // merge this cycle's lane products into the work buffer; out-of-range lanes write nothing
  always_comb begin
    work_next = work;
    for (int e = 0; e < VLEN; e++) begin
      for (int l = 0; l < MOD_COUNT; l++) begin
        if (idx + IW'(l) == IW'(e)) work_next[32*e +: 32] = lane_out[l];
      end
    end
  end

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // next-state logic and status outputs
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    last       = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        accept = start;
        if (start) state_next = RUN;
      end
      RUN: begin
        busy = 1'b1;
        last = (idx + MC_W) >= VL_W;
        if (last) state_next = DONE;
      end
      DONE: begin
        done   = 1'b1;
        accept = start;
        if (start) state_next = RUN;
      end
      default: state_next = IDLE;
    endcase
  end

  // operand capture, chunk stepping and atomic result publication
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_reg  <= '0;
      v_reg  <= '0;
      work   <= '0;
      idx    <= '0;
      result <= '0;
    end else if (accept) begin
      s_reg <= S;
      v_reg <= V;
      idx   <= '0;
    end else if (state == RUN) begin
      work <= work_next;
      if (last) begin
        idx    <= '0;
        result <= work_next;
      end else begin
        idx <= idx + MC_W;
      end
    end
  end

endmodule

// single-precision multiply: round-to-nearest-even, denormals flushed to zero, canonical NaN
module FloatingMultiplication (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] y
);

  logic               sign;
  logic [7:0]         ea, eb;
  logic [22:0]        fa, fb;
  logic               a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
  logic [47:0]        prod;
  logic signed [9:0]  exp_sum;
  logic signed [9:0]  exp_n;
  logic signed [9:0]  exp_fin;
  logic [23:0]        mant;
  logic               guard, sticky;
  logic [24:0]        rounded;
  logic [22:0]        frac;

  // normalise the 48-bit significand product, round, then resolve special operands
  always_comb begin
    sign   = a[31] ^ b[31];
    ea     = a[30:23];
    eb     = b[30:23];
    fa     = a[22:0];
    fb     = b[22:0];
    a_nan  = (ea == 8'hFF) && (fa != 23'd0);
    b_nan  = (eb == 8'hFF) && (fb != 23'd0);
    a_inf  = (ea == 8'hFF) && (fa == 23'd0);
    b_inf  = (eb == 8'hFF) && (fb == 23'd0);
    a_zero = (ea == 8'h00);
    b_zero = (eb == 8'h00);

    prod    = 48'({1'b1, fa}) * 48'({1'b1, fb});
    exp_sum = $signed({2'b00, ea}) + $signed({2'b00, eb}) - 10'sd127;
    if (prod[47]) begin
      mant   = prod[47:24];
      guard  = prod[23];
      sticky = |prod[22:0];
      exp_n  = exp_sum + 10'sd1;
    end else begin
      mant   = prod[46:23];
      guard  = prod[22];
      sticky = |prod[21:0];
      exp_n  = exp_sum;
    end
    rounded = {1'b0, mant} + 25'(guard & (sticky | mant[0]));
    if (rounded[24]) begin
      exp_fin = exp_n + 10'sd1;
      frac    = rounded[23:1];
    end else begin
      exp_fin = exp_n;
      frac    = rounded[22:0];
    end

    if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) begin
      y = 32'h7FC0_0000;
    end else if (a_inf || b_inf) begin
      y = {sign, 8'hFF, 23'd0};
    end else if (a_zero || b_zero) begin
      y = {sign, 31'd0};
    end else if (exp_fin >= 10'sd255) begin
      y = {sign, 8'hFF, 23'd0};
    end else if (exp_fin <= 10'sd0) begin
      y = {sign, 31'd0};
    end else begin
      y = {sign, exp_fin[7:0], frac};
    end
  end

endmodule

// File: tb/tb_vector_scale_seq.sv
// tb/tb_vector_scale_seq.sv - self-checking bench for vector_scale_seq
module tb_vector_scale_seq;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start_a, start_b;
  logic [31:0]  s_a, s_b;
  logic [127:0] v_a, res_a;
  logic [95:0]  v_b, res_b;
  logic         busy_a, done_a, busy_b, done_b;

  int checks = 0;
  int passed = 0;
  int fails  = 0;
  logic [127:0] prev_a = '0;
  logic [127:0] prev_b = '0;

  // a: VLEN divisible by lanes; b: last chunk has an idle lane
  vector_scale_seq #(.VLEN(4), .MOD_COUNT(2)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .S(s_a), .V(v_a),
    .result(res_a), .busy(busy_a), .done(done_a));

  vector_scale_seq #(.VLEN(3), .MOD_COUNT(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .S(s_b), .V(v_b),
    .result(res_b), .busy(busy_b), .done(done_b));

  always #5 clk = ~clk;

  function automatic real pow2(input int e);
    real r = 1.0;
    if (e >= 0) repeat (e) r = r * 2.0;
    else        repeat (-e) r = r / 2.0;
    return r;
  endfunction

  function automatic real f2r(input logic [31:0] x);
    real m;
    if (x[30:23] == 8'd0) return 0.0;
    m = (1.0 + real'(x[22:0]) / 8388608.0) * pow2(int'(x[30:23]) - 127);
    return x[31] ? -m : m;
  endfunction

  // exact real product of two 24-bit significands, rounded to nearest-even float32
  function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
    real p, m, r, f;
    int  e, fi;
    logic sgn;
    sgn = a[31] ^ b[31];
    p = f2r(a) * f2r(b);
    if (p == 0.0) return {sgn, 31'd0};
    if (p < 0.0) p = -p;
    e = 0;
    while (p >= 2.0) begin p = p / 2.0; e++; end
    while (p < 1.0)  begin p = p * 2.0; e--; end
    m  = p * 8388608.0;
    f  = $floor(m);
    r  = m - f;
    fi = $rtoi(f);
    if (r > 0.5 || (r == 0.5 && fi[0])) fi++;
    if (fi == 16777216) begin fi = 8388608; e++; end
    return {sgn, 8'(e + 127), 23'(fi - 8388608)};
  endfunction

  function automatic logic [31:0] rndf();
    logic [31:0] x;
    x = $urandom;
    x[30:23] = 8'($urandom_range(144, 110));
    return x;
  endfunction

  function automatic logic [127:0] rvec();
    logic [127:0] r;
    for (int i = 0; i < 4; i++) r[32*i +: 32] = rndf();
    return r;
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit w, input bit st, input logic [31:0] s, input logic [127:0] v);
    if (w) begin start_b = st; s_b = s; v_b = v[95:0]; end
    else   begin start_a = st; s_a = s; v_a = v;       end
  endtask

  task automatic check_out(input bit w, input string tag, input logic bsy, input logic dn,
                           input logic [127:0] res);
    chk({tag, "_busy"}, 128'(w ? busy_b : busy_a), 128'(bsy));
    chk({tag, "_done"}, 128'(w ? done_b : done_a), 128'(dn));
    chk({tag, "_result"}, w ? {32'd0, res_b} : res_a, res);
  endtask

  // one full transaction; inputs are scrambled after acceptance, poke also re-asserts start in RUN
  task automatic run(input bit w, input logic [31:0] s, input logic [127:0] v, input bit poke);
    logic [127:0] expv, old;
    int ne, n;
    ne   = w ? 3 : 4;
    n    = 2;
    expv = '0;
    for (int i = 0; i < ne; i++) expv[32*i +: 32] = fmul(s, v[32*i +: 32]);
    old = w ? prev_b : prev_a;
    @(negedge clk); drive(w, 1'b1, s, v);
    @(posedge clk); #1; check_out(w, "accept", 1'b1, 1'b0, old);
    for (int c = 1; c < n; c++) begin
      @(negedge clk); drive(w, poke, rndf(), rvec());
      @(posedge clk); #1; check_out(w, "run", 1'b1, 1'b0, old);
    end
    @(negedge clk); drive(w, 1'b0, rndf(), rvec());
    @(posedge clk); #1; check_out(w, "complete", 1'b0, 1'b1, expv);
    if (w) prev_b = expv; else prev_a = expv;
  endtask

  initial begin
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 32'd0, 128'd0);
    drive(1'b1, 1'b0, 32'd0, 128'd0);
    repeat (2) @(posedge clk);
    #1;
    check_out(1'b0, "reset_a", 1'b0, 1'b0, 128'd0);
    check_out(1'b1, "reset_b", 1'b0, 1'b0, 128'd0);
    @(negedge clk); rst_n = 1'b1;

    // 2.0 * {1,2,3,4}
    run(1'b0, 32'h4000_0000, {32'h4080_0000, 32'h4040_0000, 32'h4000_0000, 32'h3F80_0000}, 1'b0);
    chk("scale2_const", res_a, {32'h4100_0000, 32'h40C0_0000, 32'h4080_0000, 32'h4000_0000});

    // 1.0 * V leaves V unchanged on the non-divisible instance
    run(1'b1, 32'h3F80_0000, {32'd0, 32'h3F00_0000, 32'hC000_0000, 32'h4040_0000}, 1'b0);
    chk("identity_const", {32'd0, res_b}, {32'd0, 32'h3F00_0000, 32'hC000_0000, 32'h4040_0000});

    // DONE holds across idle cycles
    repeat (3) @(posedge clk);
    #1;
    check_out(1'b0, "hold_a", 1'b0, 1'b1, prev_a);
    check_out(1'b1, "hold_b", 1'b0, 1'b1, prev_b);

    // random operands, alternating ignored-start pokes during RUN
    for (int t = 0; t < 6; t++) begin
      run(1'b0, rndf(), rvec(), t[0]);
      run(1'b1, rndf(), rvec(), ~t[0]);
    end

    // restart from DONE with a zero scalar; negative elements give -0
    run(1'b1, 32'h0000_0000, {32'd0, 32'hC1A0_0000, 32'h4120_0000, 32'hBF80_0000}, 1'b0);
    chk("zero_scale", {32'd0, res_b}, {32'd0, 32'h8000_0000, 32'h0000_0000, 32'h8000_0000});

    // reset mid-RUN clears outputs before the next clock edge
    @(negedge clk); drive(1'b1, 1'b1, rndf(), rvec());
    @(posedge clk); #1;
    chk("pre_abort_busy", 128'(busy_b), 128'd1);
    @(negedge clk); drive(1'b1, 1'b0, rndf(), rvec());
    #2 rst_n = 1'b0;
    #1;
    check_out(1'b1, "abort_b", 1'b0, 1'b0, 128'd0);
    check_out(1'b0, "abort_a", 1'b0, 1'b0, 128'd0);
    prev_a = '0;
    prev_b = '0;
    @(negedge clk); rst_n = 1'b1;
    run(1'b1, rndf(), rvec(), 1'b0);
    run(1'b0, rndf(), rvec(), 1'b1);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
